// File: rtl/snitch_tcdm_split_io_wrapper.sv
// Split write/read TCDM requesters to word-interleaved banks, 1-cycle response.
// Define SNITCH_TCDM_WR_PRIORITY_EN for fixed-priority (lowest index) arbitration.
`timescale 1ns/1ps

package snitch_tcdm_pkg;
    localparam int unsigned NumWrOnly = 2;
    localparam int unsigned NumRdOnly = 2;
    localparam int unsigned NumOut    = 4;
    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 64;
    localparam int unsigned StrbWidth = DataWidth / 8;

    typedef struct packed {
        logic                 q_valid;
        logic [AddrWidth-1:0] addr;
        logic                 write;
        logic [DataWidth-1:0] data;
        logic [StrbWidth-1:0] strb;
    } tcdm_req_t;

    typedef struct packed {
        logic                 q_ready;
        logic                 p_valid;
        logic [DataWidth-1:0] p_data;
    } tcdm_rsp_t;

    typedef struct packed {
        logic                 q_valid;
        logic [AddrWidth-1:0] addr;
        logic                 write;
        logic [DataWidth-1:0] data;
        logic [StrbWidth-1:0] strb;
    } mem_req_t;

    typedef struct packed {
        logic                 q_ready;
        logic [DataWidth-1:0] p_data;
    } mem_rsp_t;
endpackage

module snitch_tcdm_split_io_wrapper
    import snitch_tcdm_pkg::*;
(
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  tcdm_req_t [NumWrOnly-1:0]   wr_req_i,
    output tcdm_rsp_t [NumWrOnly-1:0]   wr_rsp_o,
    input  tcdm_req_t [NumRdOnly-1:0]   rd_req_i,
    output tcdm_rsp_t [NumRdOnly-1:0]   rd_rsp_o,
    output mem_req_t  [NumOut-1:0]      mem_req_o,
    input  mem_rsp_t  [NumOut-1:0]      mem_rsp_i
);
    localparam int unsigned NumIn   = NumWrOnly + NumRdOnly;
    localparam int unsigned IdxW    = (NumIn > 1) ? $clog2(NumIn) : 1;
    localparam int unsigned ByteW   = $clog2(StrbWidth);
    localparam int unsigned BankW   = $clog2(NumOut);
    localparam int unsigned BankOff = ByteW + BankW;

    mem_req_t [NumIn-1:0]             in_req;
    logic     [NumIn-1:0][BankW-1:0]  in_bank;
    logic     [NumOut-1:0]            gnt_vld;
    logic     [NumOut-1:0][IdxW-1:0]  gnt_idx;
    logic     [NumOut-1:0]            hs;
    logic     [NumOut-1:0]            rsp_vld;
    logic     [NumOut-1:0][IdxW-1:0]  rsp_idx;
    logic     [NumIn-1:0]             in_rdy;
    logic     [NumIn-1:0]             in_pvld;
    logic     [NumIn-1:0][DataWidth-1:0] in_pdata;
    logic                             unused_fields;

`ifndef SNITCH_TCDM_WR_PRIORITY_EN
    logic     [NumOut-1:0][IdxW-1:0]  ptr;
`endif

    // Unified requester view: write ports first, read ports after.
    always_comb begin
        in_req        = '0;
        in_bank       = '0;
        unused_fields = 1'b0;
        for (int unsigned i = 0; i < NumWrOnly; i++) begin
            in_req[i]       = wr_req_i[i];
            in_req[i].write = 1'b1;
            unused_fields   = unused_fields ^ wr_req_i[i].write;
        end
        for (int unsigned j = 0; j < NumRdOnly; j++) begin
            in_req[NumWrOnly+j].q_valid = rd_req_i[j].q_valid;
            in_req[NumWrOnly+j].addr    = rd_req_i[j].addr;
            unused_fields = unused_fields ^ (^{rd_req_i[j].write,
                                              rd_req_i[j].data,
                                              rd_req_i[j].strb});
        end
        for (int unsigned i = 0; i < NumIn; i++) begin
            in_bank[i] = in_req[i].addr[ByteW +: BankW];
        end
    end

    always_comb begin
        logic [IdxW-1:0] idx;
        idx     = '0;
        gnt_vld = '0;
        gnt_idx = '0;
        for (int unsigned b = 0; b < NumOut; b++) begin
            for (int unsigned k = 0; k < NumIn; k++) begin
`ifdef SNITCH_TCDM_WR_PRIORITY_EN
                idx = IdxW'(k);
`else
                idx = IdxW'((32'(ptr[b]) + k) % NumIn);
`endif
                if (!gnt_vld[b] && in_req[idx].q_valid &&
                    in_bank[idx] == BankW'(b)) begin
                    gnt_vld[b] = 1'b1;
                    gnt_idx[b] = idx;
                end
            end
        end
    end

    always_comb begin
        mem_req_o = '0;
        hs        = '0;
        for (int unsigned b = 0; b < NumOut; b++) begin
            if (rst_ni && gnt_vld[b]) begin
                mem_req_o[b]      = in_req[gnt_idx[b]];
                mem_req_o[b].addr = in_req[gnt_idx[b]].addr >> BankOff;
            end
            hs[b] = mem_req_o[b].q_valid && mem_rsp_i[b].q_ready;
        end
    end

    always_comb begin
        in_rdy   = '0;
        in_pvld  = '0;
        in_pdata = '0;
        for (int unsigned b = 0; b < NumOut; b++) begin
            for (int unsigned i = 0; i < NumIn; i++) begin
                if (hs[b] && gnt_idx[b] == IdxW'(i)) begin
                    in_rdy[i] = 1'b1;
                end
                if (rsp_vld[b] && rsp_idx[b] == IdxW'(i)) begin
                    in_pvld[i] = 1'b1;
                    if (i >= NumWrOnly) begin
                        in_pdata[i] = mem_rsp_i[b].p_data;
                    end
                end
            end
        end
    end

    always_comb begin
        wr_rsp_o = '0;
        rd_rsp_o = '0;
        for (int unsigned i = 0; i < NumWrOnly; i++) begin
            wr_rsp_o[i].q_ready = in_rdy[i];
            wr_rsp_o[i].p_valid = in_pvld[i];
            wr_rsp_o[i].p_data  = in_pdata[i];
        end
        for (int unsigned j = 0; j < NumRdOnly; j++) begin
            rd_rsp_o[j].q_ready = in_rdy[NumWrOnly+j];
            rd_rsp_o[j].p_valid = in_pvld[NumWrOnly+j];
            rd_rsp_o[j].p_data  = in_pdata[NumWrOnly+j];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_vld <= '0;
            rsp_idx <= '0;
        end else begin
            rsp_vld <= hs;
            for (int unsigned b = 0; b < NumOut; b++) begin
                if (hs[b]) begin
                    rsp_idx[b] <= gnt_idx[b];
                end
            end
        end
    end

`ifndef SNITCH_TCDM_WR_PRIORITY_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr <= '0;
        end else begin
            for (int unsigned b = 0; b < NumOut; b++) begin
                if (hs[b]) begin
                    ptr[b] <= (gnt_idx[b] == IdxW'(NumIn - 1)) ? '0
                                                                : gnt_idx[b] + 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_snitch_tcdm_split_io_wrapper.sv
// Scoreboard bench: directed scenarios plus random traffic against a bank model.
`timescale 1ns/1ps

module tb_snitch_tcdm_split_io_wrapper;
    import snitch_tcdm_pkg::*;

    localparam int NW = NumWrOnly;
    localparam int NI = NumWrOnly + NumRdOnly;

    logic clk_i = 1'b0;
    logic rst_ni;
    tcdm_req_t [NumWrOnly-1:0] wr_req_i;
    tcdm_rsp_t [NumWrOnly-1:0] wr_rsp_o;
    tcdm_req_t [NumRdOnly-1:0] rd_req_i;
    tcdm_rsp_t [NumRdOnly-1:0] rd_rsp_o;
    mem_req_t  [NumOut-1:0]    mem_req_o;
    mem_rsp_t  [NumOut-1:0]    mem_rsp_i;

    always #5 clk_i = ~clk_i;

    snitch_tcdm_split_io_wrapper dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .wr_req_i  (wr_req_i),
        .wr_rsp_o  (wr_rsp_o),
        .rd_req_i  (rd_req_i),
        .rd_rsp_o  (rd_rsp_o),
        .mem_req_o (mem_req_o),
        .mem_rsp_i (mem_rsp_i)
    );

    typedef struct {
        int due;
        int bank;
        bit rd;
    } exp_t;

    exp_t q[NI][$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   rr_ptr[NumOut];
    bit   granted[NI];
    bit   exp_rdy[NI];

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic tcdm_req_t req_of(input int i);
        return (i < NW) ? wr_req_i[i] : rd_req_i[i-NW];
    endfunction

    function automatic tcdm_rsp_t rsp_of(input int i);
        return (i < NW) ? wr_rsp_o[i] : rd_rsp_o[i-NW];
    endfunction

    always @(posedge clk_i) cyc++;

    // Reference: who each bank should grant, what it should see, what comes back.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            for (int b = 0; b < NumOut; b++) begin
                chk($sformatf("rst_mem_req[%0d]", b), 128'(mem_req_o[b]), 128'(0));
                rr_ptr[b] = 0;
            end
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("rst_rsp[%0d]", i), 128'(rsp_of(i)), 128'(0));
                q[i].delete();
                granted[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < NI; i++) exp_rdy[i] = 1'b0;
            for (int b = 0; b < NumOut; b++) begin
                int winner;
                int best;
                mem_req_t em;
                tcdm_req_t r;
                winner = -1;
                best   = NI;
                for (int i = 0; i < NI; i++) begin
                    int key;
                    r = req_of(i);
`ifdef SNITCH_TCDM_WR_PRIORITY_EN
                    key = i;
`else
                    key = (i - rr_ptr[b] + NI) % NI;
`endif
                    if (r.q_valid && ((r.addr / StrbWidth) % NumOut) == b &&
                        key < best) begin
                        best   = key;
                        winner = i;
                    end
                end
                em = '0;
                if (winner >= 0) begin
                    r          = req_of(winner);
                    em.q_valid = 1'b1;
                    em.addr    = r.addr / (StrbWidth * NumOut);
                    em.write   = (winner < NW);
                    em.data    = (winner < NW) ? r.data : '0;
                    em.strb    = (winner < NW) ? r.strb : '0;
                end
                chk($sformatf("mem_req[%0d]", b), 128'(mem_req_o[b]), 128'(em));
                if (winner >= 0 && mem_rsp_i[b].q_ready) begin
                    exp_rdy[winner] = 1'b1;
                    q[winner].push_back('{due: cyc + 1, bank: b, rd: winner >= NW});
                    rr_ptr[b] = (winner + 1) % NI;
                end
            end
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("q_ready[%0d]", i), 128'(rsp_of(i).q_ready),
                    128'(exp_rdy[i]));
                granted[i] = exp_rdy[i];
            end
        end
    end

    // Monitor: pops expected responses when they fall due.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            for (int i = 0; i < NI; i++) begin
                tcdm_rsp_t rs;
                bit expv;
                exp_t e;
                rs   = rsp_of(i);
                expv = (q[i].size() > 0) && (q[i][0].due == cyc);
                chk($sformatf("p_valid[%0d]", i), 128'(rs.p_valid), 128'(expv));
                if (expv) begin
                    e = q[i].pop_front();
                    chk($sformatf("p_data[%0d]", i), 128'(rs.p_data),
                        e.rd ? 128'(mem_rsp_i[e.bank].p_data) : 128'(0));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_reqs();
        wr_req_i = '0;
        rd_req_i = '0;
    endtask

    task automatic set_ready(input bit v);
        for (int b = 0; b < NumOut; b++) mem_rsp_i[b].q_ready = v;
    endtask

    function automatic tcdm_req_t mk(input logic [31:0] a, input logic w,
                                     input logic [63:0] d, input logic [7:0] s);
        tcdm_req_t r;
        r.q_valid = 1'b1;
        r.addr    = a;
        r.write   = w;
        r.data    = d;
        r.strb    = s;
        return r;
    endfunction

    initial begin
        mem_req_t ew;
        rst_ni    = 1'b0;
        clear_reqs();
        mem_rsp_i = '0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        repeat (50) step();

        // Bank mapping: read 0x18 lands on bank 3, row 0.
        set_ready(1'b1);
        mem_rsp_i[3].p_data = 64'hDEADBEEF;
        rd_req_i[0] = mk(32'h18, 1'b1, 64'hA5A5_5A5A, 8'hFF);
        @(negedge clk_i);
        chk("map_q_valid", 128'(mem_req_o[3].q_valid), 128'(1));
        chk("map_write", 128'(mem_req_o[3].write), 128'(0));
        chk("map_addr", 128'(mem_req_o[3].addr), 128'(0));
        chk("map_data", 128'(mem_req_o[3].data), 128'(0));
        step();
        rd_req_i[0] = '0;
        @(negedge clk_i);
        chk("map_p_valid", 128'(rd_rsp_o[0].p_valid), 128'(1));
        chk("map_p_data", 128'(rd_rsp_o[0].p_data), 128'(64'hDEADBEEF));
        step();

        // Write path.
        wr_req_i[1] = mk(32'h20, 1'b0, 64'h1234, 8'h0F);
        ew = '{q_valid: 1'b1, addr: 32'h1, write: 1'b1, data: 64'h1234, strb: 8'h0F};
        @(negedge clk_i);
        chk("wr_mem_req", 128'(mem_req_o[0]), 128'(ew));
        step();
        wr_req_i[1] = '0;
        @(negedge clk_i);
        chk("wr_p_valid", 128'(wr_rsp_o[1].p_valid), 128'(1));
        chk("wr_p_data", 128'(wr_rsp_o[1].p_data), 128'(0));
        step();

        // Conflict on bank 1.
        rd_req_i[0] = mk(32'h08, 1'b0, 64'h0, 8'h0);
        rd_req_i[1] = mk(32'h08, 1'b0, 64'h0, 8'h0);
        @(negedge clk_i);
        chk("cf_c1_rd0", 128'(rd_rsp_o[0].q_ready), 128'(1));
        chk("cf_c1_rd1", 128'(rd_rsp_o[1].q_ready), 128'(0));
        step();
        rd_req_i[0] = '0;
        @(negedge clk_i);
        chk("cf_c2_rd1", 128'(rd_rsp_o[1].q_ready), 128'(1));
        chk("cf_c2_pv0", 128'(rd_rsp_o[0].p_valid), 128'(1));
        step();
        rd_req_i[1] = '0;
        step();

        // Parallel banks 0 and 1.
        wr_req_i[0] = mk(32'h00, 1'b0, 64'h77, 8'hF0);
        rd_req_i[0] = mk(32'h08, 1'b0, 64'h0, 8'h0);
        @(negedge clk_i);
        chk("par_wr0", 128'(wr_rsp_o[0].q_ready), 128'(1));
        chk("par_rd0", 128'(rd_rsp_o[0].q_ready), 128'(1));
        step();
        clear_reqs();
        step();

        // Stall: request held, no grant.
        set_ready(1'b0);
        rd_req_i[1] = mk(32'h10, 1'b0, 64'h0, 8'h0);
        repeat (3) begin
            @(negedge clk_i);
            chk("stall_rdy", 128'(rd_rsp_o[1].q_ready), 128'(0));
            step();
        end
        set_ready(1'b1);
        step();
        clear_reqs();
        step();

        // Handshake index 2 on bank 1, then reset while the response is due.
        rd_req_i[0] = mk(32'h08, 1'b0, 64'h0, 8'h0);
        step();
        rd_req_i[0] = '0;
        rst_ni = 1'b0;
        @(negedge clk_i);
        chk("rst_no_pvalid", 128'(rd_rsp_o[0].p_valid), 128'(0));
        step();
        rst_ni = 1'b1;
        step();
        rd_req_i[0] = mk(32'h08, 1'b0, 64'h0, 8'h0);
        rd_req_i[1] = mk(32'h08, 1'b0, 64'h0, 8'h0);
        @(negedge clk_i);
        chk("rst_ptr_rd0", 128'(rd_rsp_o[0].q_ready), 128'(1));
        step();
        clear_reqs();
        step();

        // Random traffic; a port only changes after the model saw it granted.
        repeat (3000) begin
            for (int i = 0; i < NI; i++) begin
                tcdm_req_t r;
                r = req_of(i);
                if (!r.q_valid || granted[i]) begin
                    r = '0;
                    if ($urandom_range(0, 1) == 1) begin
                        r = mk($urandom, 1'($urandom), {$urandom, $urandom},
                               8'($urandom));
                    end
                    if (i < NW) wr_req_i[i] = r;
                    else        rd_req_i[i-NW] = r;
                end
            end
            for (int b = 0; b < NumOut; b++) begin
                mem_rsp_i[b].q_ready = ($urandom_range(0, 3) != 0);
                mem_rsp_i[b].p_data  = {$urandom, $urandom};
            end
            step();
        end

        clear_reqs();
        set_ready(1'b1);
        repeat (5) step();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("drain[%0d]", i), 128'(q[i].size()), 128'(0));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
